// File: rtl/filter_iir_pkg.sv
// Shared definitions for the SOS IIR cascade: FSM encoding, coefficient slot indices and
// arithmetic helpers used to size the accumulator and its saturation limits.
package filter_iir_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StUpd, StDone} state_e;

  localparam int unsigned N_COEF = 5;

  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  function automatic int unsigned acc_width(input int unsigned bw);
    return 2 * bw + 3;
  endfunction

  function automatic logic signed [63:0] sat_max(input int unsigned bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/iir_sos_mac.sv
// Shared multiply-accumulate for the SOS cascade: signed product, accumulator with
// clear/subtract control and the arithmetic shift plus saturation back to data width.
module iir_sos_mac
  import filter_iir_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned BIT_FRAC  = 14,
  parameter bit          FPGA_MULT = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        sub,
  input  logic signed [BIT_WIDTH-1:0] coef,
  input  logic signed [BIT_WIDTH-1:0] data,
  output logic signed [BIT_WIDTH-1:0] result
);

  localparam int unsigned ACC_W  = acc_width(BIT_WIDTH);
  localparam int unsigned PROD_W = 2 * BIT_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(BIT_WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(BIT_WIDTH));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_shr;

  if (FPGA_MULT) begin : g_fpga_mult
    // Explicit sign replication keeps the operand shape a DSP slice expects
    logic signed [PROD_W-1:0] coef_ext, data_ext;
    assign coef_ext = {{BIT_WIDTH{coef[BIT_WIDTH-1]}}, coef};
    assign data_ext = {{BIT_WIDTH{data[BIT_WIDTH-1]}}, data};
    assign prod     = coef_ext * data_ext;
  end else begin : g_asic_mult
    assign prod = PROD_W'(coef) * PROD_W'(data);
  end

  assign prod_ext = ACC_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = (clr ? '0 : acc_q) + (sub ? -prod_ext : prod_ext);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_shr = acc_q >>> BIT_FRAC;

  always_comb begin
    result = acc_shr[BIT_WIDTH-1:0];
    if (acc_shr > SAT_HI) begin
      result = SAT_HI[BIT_WIDTH-1:0];
    end else if (acc_shr < SAT_LO) begin
      result = SAT_LO[BIT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/filter_iir_sos_cascade.sv
// Multi-channel cascade of Direct Form 1 biquads sharing one MAC; each sample walks all
// sections, five products per section, then a tap-update cycle.
module filter_iir_sos_cascade
  import filter_iir_pkg::*;
#(
  parameter int unsigned  BIT_WIDTH = 16,
  parameter int unsigned  BIT_FRAC  = 14,
  parameter int unsigned  N_SECT    = 2,
  parameter int unsigned  N_CH      = 4,
  parameter bit           UINT_IO   = 1'b0,
  parameter bit           FPGA_MULT = 1'b0,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned CA_W      = $clog2(N_COEF * N_SECT)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CH_W-1:0]      CH_IN,
  input  logic [BIT_WIDTH-1:0] DATA_IN,
  output logic                 RDY,
  output logic [BIT_WIDTH-1:0] DATA_OUT,
  output logic [CH_W-1:0]      CH_OUT,
  output logic                 DOUT_VALID,
  input  logic                 COEF_WE,
  input  logic [CA_W-1:0]      COEF_ADDR,
  input  logic [BIT_WIDTH-1:0] COEF_DATA,
  output logic                 COEF_ERR,
  input  logic                 TAP_CLR
);

  localparam int unsigned S_W     = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int unsigned N_COEFS = N_COEF * N_SECT;
  localparam logic [CH_W:0] N_CH_L    = (CH_W + 1)'(N_CH);
  localparam logic [CA_W:0] N_COEFS_L = (CA_W + 1)'(N_COEFS);
  localparam logic [S_W-1:0] LAST_S   = S_W'(N_SECT - 1);
  localparam logic signed [BIT_WIDTH-1:0] COEF_ONE = BIT_WIDTH'(1 << BIT_FRAC);

  state_e state_q, state_d;
  logic   rdy, mac_en, mac_clr, mac_sub, upd, done;

  logic [2:0]                  k_q;
  logic [S_W-1:0]              s_q;
  logic [CH_W-1:0]             ch_q;
  logic signed [BIT_WIDTH-1:0] x_q, x_in, y, op_coef, op_data;
  logic [CA_W-1:0]             coef_idx;
  logic                        ch_ok, accept, addr_ok, coef_wr;

  logic signed [BIT_WIDTH-1:0] coef_q [N_COEFS];
  logic signed [BIT_WIDTH-1:0] x1_q [N_CH][N_SECT];
  logic signed [BIT_WIDTH-1:0] x2_q [N_CH][N_SECT];
  logic signed [BIT_WIDTH-1:0] y1_q [N_CH][N_SECT];
  logic signed [BIT_WIDTH-1:0] y2_q [N_CH][N_SECT];

  logic signed [BIT_WIDTH-1:0] dout_q;
  logic [CH_W-1:0]             ch_out_q;
  logic                        dout_valid_q, coef_err_q;

  assign ch_ok   = {1'b0, CH_IN} < N_CH_L;
  assign accept  = (state_q == StIdle) && START && ch_ok;
  assign addr_ok = {1'b0, COEF_ADDR} < N_COEFS_L;
  assign coef_wr = COEF_WE && (state_q == StIdle) && addr_ok;
  assign x_in    = UINT_IO ? {~DATA_IN[BIT_WIDTH-1], DATA_IN[BIT_WIDTH-2:0]} : DATA_IN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (k_q == K_A2) state_d = StUpd;
      StUpd:   state_d = (s_q == LAST_S) ? StDone : StMac;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdy     = (state_q == StIdle);
    mac_en  = (state_q == StMac);
    mac_clr = mac_en && (k_q == K_B0);
    mac_sub = (k_q >= K_A1);
    upd     = (state_q == StUpd);
    done    = (state_q == StDone);
  end

  // Operand pair for the current product; feedback terms are subtracted in the MAC
  always_comb begin
    coef_idx = CA_W'(s_q) * CA_W'(N_COEF) + CA_W'(k_q);
    op_coef  = coef_q[coef_idx];
    case (k_q)
      K_B0:    op_data = x_q;
      K_B1:    op_data = x1_q[ch_q][s_q];
      K_B2:    op_data = x2_q[ch_q][s_q];
      K_A1:    op_data = y1_q[ch_q][s_q];
      K_A2:    op_data = y2_q[ch_q][s_q];
      default: op_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k_q  <= '0;
      s_q  <= '0;
      ch_q <= '0;
      x_q  <= '0;
    end else begin
      if (accept) begin
        ch_q <= CH_IN;
        x_q  <= x_in;
        s_q  <= '0;
        k_q  <= '0;
      end
      if (mac_en) begin
        k_q <= (k_q == K_A2) ? K_B0 : k_q + 3'd1;
      end
      if (upd) begin
        x_q <= y;
        if (s_q != LAST_S) begin
          s_q <= s_q + S_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || (rdy && TAP_CLR)) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int s = 0; s < N_SECT; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
      end
    end else if (upd) begin
      x1_q[ch_q][s_q] <= x_q;
      x2_q[ch_q][s_q] <= x1_q[ch_q][s_q];
      y1_q[ch_q][s_q] <= y;
      y2_q[ch_q][s_q] <= y1_q[ch_q][s_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_COEFS; i++) begin
        coef_q[i] <= ((i % N_COEF) == 0) ? COEF_ONE : '0;
      end
    end else if (coef_wr) begin
      coef_q[COEF_ADDR] <= COEF_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q       <= '0;
      ch_out_q     <= '0;
      dout_valid_q <= 1'b0;
      coef_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= done;
      coef_err_q   <= COEF_WE && !coef_wr;
      if (done) begin
        dout_q   <= x_q;
        ch_out_q <= ch_q;
      end
    end
  end

  iir_sos_mac #(
    .BIT_WIDTH (BIT_WIDTH),
    .BIT_FRAC  (BIT_FRAC),
    .FPGA_MULT (FPGA_MULT)
  ) u_mac (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (mac_clr),
    .en     (mac_en),
    .sub    (mac_sub),
    .coef   (op_coef),
    .data   (op_data),
    .result (y)
  );

  assign RDY        = rdy;
  assign DATA_OUT   = UINT_IO ? {~dout_q[BIT_WIDTH-1], dout_q[BIT_WIDTH-2:0]} : dout_q;
  assign CH_OUT     = ch_out_q;
  assign DOUT_VALID = dout_valid_q;
  assign COEF_ERR   = coef_err_q;

endmodule

// File: tb/tb_filter_iir_sos_cascade.sv
// Directed bench for the SOS cascade (2 sections, 3 channels): passthrough, impulse decay,
// channel isolation, coefficient write rules, saturation and reset abort.
module tb_filter_iir_sos_cascade;

  logic        CLK = 1'b0;
  logic        RST, START, COEF_WE, TAP_CLR;
  logic        RDY, DOUT_VALID, COEF_ERR;
  logic [1:0]  CH_IN, CH_OUT;
  logic [15:0] DATA_IN, DATA_OUT, COEF_DATA;
  logic [3:0]  COEF_ADDR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dout;
  logic [1:0]  chout;
  int          lat;
  int          seen;

  always #5 CLK = ~CLK;

  filter_iir_sos_cascade #(
    .BIT_WIDTH (16),
    .BIT_FRAC  (14),
    .N_SECT    (2),
    .N_CH      (3),
    .UINT_IO   (1'b0),
    .FPGA_MULT (1'b0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .CH_IN      (CH_IN),
    .DATA_IN    (DATA_IN),
    .RDY        (RDY),
    .DATA_OUT   (DATA_OUT),
    .CH_OUT     (CH_OUT),
    .DOUT_VALID (DOUT_VALID),
    .COEF_WE    (COEF_WE),
    .COEF_ADDR  (COEF_ADDR),
    .COEF_DATA  (COEF_DATA),
    .COEF_ERR   (COEF_ERR),
    .TAP_CLR    (TAP_CLR)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic coef_write(input logic [3:0] addr, input logic [15:0] data);
    COEF_WE   = 1'b1;
    COEF_ADDR = addr;
    COEF_DATA = data;
    tick();
    COEF_WE   = 1'b0;
  endtask

  // Issues one START, then waits (bounded) for the output strobe.
  task automatic run_sample(input logic [1:0] ch, input logic [15:0] din, input logic clr,
                            output logic [15:0] o_data, output logic [1:0] o_ch,
                            output int o_lat);
    CH_IN   = ch;
    DATA_IN = din;
    TAP_CLR = clr;
    START   = 1'b1;
    tick();
    START   = 1'b0;
    TAP_CLR = 1'b0;
    COEF_WE = 1'b0;
    o_lat   = 0;
    while (!DOUT_VALID && o_lat < 40) begin
      tick();
      o_lat++;
    end
    o_data = DATA_OUT;
    o_ch   = CH_OUT;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (DOUT_VALID) n++;
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; COEF_WE = 1'b0; TAP_CLR = 1'b0;
    CH_IN = '0; DATA_IN = '0; COEF_ADDR = '0; COEF_DATA = '0;
    tick();
    tick();
    RST = 1'b0;

    chk("rst_rdy", RDY, 1);
    chk("rst_dout", DATA_OUT, 16'h0000);
    chk("rst_chout", CH_OUT, 0);
    chk("rst_valid", DOUT_VALID, 0);
    chk("rst_coef_err", COEF_ERR, 0);

    // Reset coefficients pass samples straight through both sections
    run_sample(2'd0, 16'h1234, 1'b0, dout, chout, lat);
    chk("pass_lat", lat, 13);
    chk("pass_data", dout, 16'h1234);
    chk("pass_rdy", RDY, 1);
    tick();
    chk("pass_pulse", DOUT_VALID, 0);
    chk("pass_hold", DATA_OUT, 16'h1234);

    // y = 0.5*x + 0.5*y1 in section 0
    coef_write(4'd0, 16'h2000);
    chk("wr_b0_err", COEF_ERR, 0);
    coef_write(4'd3, 16'hE000);
    run_sample(2'd0, 16'h4000, 1'b1, dout, chout, lat);
    chk("imp0_lat", lat, 13);
    chk("imp0_data", dout, 16'h2000);
    run_sample(2'd0, 16'h0000, 1'b0, dout, chout, lat);
    chk("imp1_data", dout, 16'h1000);
    run_sample(2'd0, 16'h0000, 1'b0, dout, chout, lat);
    chk("imp2_data", dout, 16'h0800);
    chk("imp2_ch", chout, 0);

    // Interleaved channels keep separate state; TAP_CLR rides along with START
    run_sample(2'd0, 16'h4000, 1'b1, dout, chout, lat);
    chk("ch0_a", dout, 16'h2000);
    run_sample(2'd1, 16'h0000, 1'b0, dout, chout, lat);
    chk("ch1_a", dout, 16'h0000);
    chk("ch1_a_ch", chout, 1);
    run_sample(2'd0, 16'h0000, 1'b0, dout, chout, lat);
    chk("ch0_b", dout, 16'h1000);
    chk("ch0_b_ch", chout, 0);
    run_sample(2'd1, 16'h0000, 1'b0, dout, chout, lat);
    chk("ch1_b", dout, 16'h0000);

    // Channel index beyond N_CH is a no-op
    CH_IN = 2'd3; DATA_IN = 16'h1111; START = 1'b1;
    tick();
    START = 1'b0;
    chk("badch_rdy", RDY, 1);
    count_valid(16, seen);
    chk("badch_novalid", seen, 0);

    // Coefficient write while busy is rejected
    CH_IN = 2'd1; DATA_IN = 16'h0000; START = 1'b1;
    tick();
    START = 1'b0;
    chk("busy_rdy", RDY, 0);
    tick();
    coef_write(4'd0, 16'h7FFF);
    chk("busy_err", COEF_ERR, 1);
    tick();
    chk("busy_err_pulse", COEF_ERR, 0);
    lat = 0;
    while (!DOUT_VALID && lat < 40) begin
      tick();
      lat++;
    end
    chk("busy_done", DOUT_VALID, 1);
    run_sample(2'd0, 16'h4000, 1'b1, dout, chout, lat);
    chk("old_coef", dout, 16'h2000);

    coef_write(4'd10, 16'h1234);
    chk("addr_oob_err", COEF_ERR, 1);
    coef_write(4'd9, 16'h0000);
    chk("addr_last_ok", COEF_ERR, 0);

    // Saturation; the b0 write lands in the same cycle as START
    coef_write(4'd3, 16'h0000);
    COEF_WE = 1'b1; COEF_ADDR = 4'd0; COEF_DATA = 16'h7FFF;
    run_sample(2'd0, 16'h7000, 1'b0, dout, chout, lat);
    chk("sat_pos", dout, 16'h7FFF);
    chk("sat_pos_err", COEF_ERR, 0);
    run_sample(2'd0, 16'h9000, 1'b0, dout, chout, lat);
    chk("sat_neg", dout, 16'h8000);

    // Reset during MAC aborts the sample and restores passthrough
    CH_IN = 2'd0; DATA_IN = 16'h0100; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_rdy", RDY, 1);
    chk("abort_valid", DOUT_VALID, 0);
    count_valid(20, seen);
    chk("abort_novalid", seen, 0);
    run_sample(2'd0, 16'h0100, 1'b0, dout, chout, lat);
    chk("post_rst_lat", lat, 13);
    chk("post_rst_data", dout, 16'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
